fir_frame_collector: RTL

Receiver for the FIR output stream (`fir_valid`/`fir_d`). It packs consecutive filtered samples into N-sample frames and presents each frame as a parallel word with a valid/ready handshake to the downstream FFT stage. Ping-pong double buffering lets a continuous one-sample-per-cycle FIR stream be absorbed while the FFT consumes the previous frame. The block flags lost samples and stops after a fixed number of frames.

---
 rtl/fa_pkg.sv | 10 +
 rtl/fir_frame_collector_if.sv | 45 ++++
 rtl/frame_bank.sv | 37 +++
 rtl/fir_frame_collector.sv | 113 +++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared constants and sample type for the FIR frame collector and its bank sub-module.
package fa_pkg;

    localparam int FA_N      = 16;
    localparam int FA_W      = 16;
    localparam int FA_FRAMES = 64;

    typedef logic signed [FA_W-1:0] sample_t;

endpackage : fa_pkg

// File: rtl/fir_frame_collector_if.sv
// FIR sample stream in, parallel frame handshake out, plus run status.
interface fir_frame_collector_if
    import fa_pkg::*;
#(
    parameter int N      = FA_N,
    parameter int W      = FA_W,
    parameter int FRAMES = FA_FRAMES
) ();

    localparam int CW = $clog2(FRAMES + 1);

    logic                fir_valid;
    logic signed [W-1:0] fir_d;
    logic                frame_valid;
    logic                frame_ready;
    logic [N*W-1:0]      frame_data;
    logic [CW-1:0]       frame_cnt;
    logic                overflow;
    logic                done;

    // The collector side: consumes samples, produces frames.
    modport master (
        input  fir_valid,
        input  fir_d,
        input  frame_ready,
        output frame_valid,
        output frame_data,
        output frame_cnt,
        output overflow,
        output done
    );

    // The environment side: FIR source plus FFT consumer.
    modport slave (
        output fir_valid,
        output fir_d,
        output frame_ready,
        input  frame_valid,
        input  frame_data,
        input  frame_cnt,
        input  overflow,
        input  done
    );

endinterface : fir_frame_collector_if

// File: rtl/frame_bank.sv
// One N x W sample bank: indexed single-sample write, whole bank visible as a flat read bus.
module frame_bank
    import fa_pkg::*;
#(
    parameter int N  = FA_N,
    parameter int W  = FA_W,
    parameter int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we_i,
    input  logic [IW-1:0]  idx_i,
    input  logic [W-1:0]   wdata_i,
    output logic [N*W-1:0] rdata_o
);

    logic [W-1:0] mem_q [N];

    // NOTE: every cell is cleared on reset because the whole bank is visible on
    // frame_data; stale contents would leak out after reset.
    // NOTE: sequential state is assigned with <= so all registers update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_flat
        assign rdata_o[k*W +: W] = mem_q[k];
    end

endmodule : frame_bank

// File: rtl/fir_frame_collector.sv
// Ping-pong frame collector: packs FIR samples into N-sample frames for the FFT stage.
module fir_frame_collector
    import fa_pkg::*;
#(
    parameter int N      = FA_N,
    parameter int W      = FA_W,
    parameter int FRAMES = FA_FRAMES
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_frame_collector_if.master bus
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(FRAMES + 1);

    logic          wbank_q, wbank_d;
    logic [IW-1:0] widx_q, widx_d;
    logic [1:0]    full_q, full_d;
    logic          rbank_q, rbank_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;

    logic           wr_en, wr_last, drop, hs;
    logic [1:0]     bank_we;
    logic [N*W-1:0] bank_data [2];

    // Write and read sides both decide from pre-edge state, so a completion on
    // one bank and a handshake on the other in the same cycle never collide.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        wbank_d    = wbank_q;
        widx_d     = widx_q;
        full_d     = full_q;
        rbank_d    = rbank_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        done_d     = done_q;

        wr_en   = bus.fir_valid && !done_q && !full_q[wbank_q];
        drop    = bus.fir_valid && !done_q && full_q[wbank_q];
        wr_last = wr_en && (widx_q == IW'(N - 1));
        hs      = full_q[rbank_q] && !done_q && bus.frame_ready;

        bank_we    = 2'b00;
        bank_we[0] = wr_en && !wbank_q;
        bank_we[1] = wr_en && wbank_q;

        if (wr_en) begin
            widx_d = widx_q + IW'(1);
        end
        if (wr_last) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = !wbank_q;
            widx_d          = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        if (hs) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = !rbank_q;
            cnt_d           = cnt_q + CW'(1);
            if (cnt_q == CW'(FRAMES - 1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank_q    <= 1'b0;
            widx_q     <= '0;
            full_q     <= 2'b00;
            rbank_q    <= 1'b0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wbank_q    <= wbank_d;
            widx_q     <= widx_d;
            full_q     <= full_d;
            rbank_q    <= rbank_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank #(
            .N (N),
            .W (W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we_i    (bank_we[b]),
            .idx_i   (widx_q),
            .wdata_i (bus.fir_d),
            .rdata_o (bank_data[b])
        );
    end

    // Once done, any frame written before the final handshake is withheld.
    assign bus.frame_valid = full_q[rbank_q] && !done_q;
    assign bus.frame_data  = rbank_q ? bank_data[1] : bank_data[0];
    assign bus.frame_cnt   = cnt_q;
    assign bus.overflow    = overflow_q;
    assign bus.done        = done_q;

endmodule : fir_frame_collector
